scan_bist_ctrl: RTL and testbench
=================================

# scan_bist_ctrl

Logic BIST controller that wraps a scan-inserted benchmark core. It drives the core's scan-enable, scan-in and primary inputs from an on-chip LFSR, and compacts the core's scan-out and primary outputs into a MISR. At the end of a run it flags pass/fail against a golden signature. It sits directly upstream of the core's scan chain, feeding `test_si`, `test_se` and the primary inputs, and directly downstream of the core's last scan cell and primary outputs.

## Interface
- CHAIN_LEN, 14, scan cells in the core's chain (≥2)
- NUM_PATTERNS, 64, load/capture patterns per run (≥1)
- PI_W, 3, core primary inputs driven (≤15)
- PO_W, 6, core primary outputs compacted (≤15)
- SEED, 16'hACE1, LFSR start value (non-zero)
- GOLDEN, 16'h0000, expected final MISR value
- CK  in  1  clock, rising edge
- RN  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE/DONE only
- scan_so  in  1  core scan-out (last chain cell Q)
- po  in  PO_W  core primary outputs
- test_se  out  1  core scan enable
- test_si  out  1  core scan-in
- pi  out  PI_W  core primary inputs
- busy  out  1  run in progress
- done  out  1  run complete (sticky)
- pass  out  1  signature match, valid when done=1
- signature  out  16  current MISR value

## Operation
- One clock domain. Reset is asynchronous and active-low.
- FSM states are IDLE, SHIFT, CAPTURE, UNLOAD and DONE.
  - IDLE→SHIFT on start=1. DONE→SHIFT on start=1.
  - SHIFT runs for CHAIN_LEN cycles, then →CAPTURE.
  - CAPTURE lasts 1 cycle. It goes →SHIFT if patterns remain, else →UNLOAD.
  - UNLOAD runs for CHAIN_LEN cycles, then →DONE.
- On any start: lfsr←SEED, misr←0, shift and pattern counters←0, done←0, pass←0.
- LFSR is 16-bit Fibonacci: fb=l[0]^l[2]^l[3]^l[5]; next={fb,l[15:1]}.
  - It advances only on SHIFT cycles and holds otherwise.
- MISR is 16-bit: fb=m[15]^m[13]^m[12]^m[10]; next={m[14:0],fb}^d.
  - It updates in SHIFT (except pattern 0), CAPTURE and UNLOAD; it holds in IDLE and DONE.
  - In SHIFT/UNLOAD, d = 16'b0 with d[0]=scan_so.
  - In CAPTURE, d[PO_W:1]=po and all other bits are 0.
- The pattern-0 SHIFT ignores scan_so, because the core's chain is unreset (X) before the first load.
- Outputs (Moore, functions of the state/LFSR registers only):
  - test_se=1 in SHIFT/UNLOAD, 0 otherwise.
  - test_si=l[0] in SHIFT, 0 otherwise.
  - pi=l[PI_W:1] in CAPTURE, 0 otherwise.
  - busy=1 in SHIFT/CAPTURE/UNLOAD.
- done=1 in DONE. pass=(misr==GOLDEN) is registered on entry to DONE and held. signature=misr at all times.
- start while busy=1 is ignored.

## Timing
- Reset values: test_se=0, test_si=0, pi=0, busy=0, done=0, pass=0, signature=0. LFSR=SEED, FSM=IDLE.
- RN low mid-run aborts immediately to these reset values. The core chain contents are then undefined, and the next run re-masks pattern 0.
- start sampled high at edge k puts the FSM in SHIFT after edge k; the first test_si bit (SEED[0]) is valid in cycle k+1.
- Run length from the first SHIFT cycle to DONE is NUM_PATTERNS·(CHAIN_LEN+1)+CHAIN_LEN cycles.
- The core captures on the edge ending the CAPTURE cycle, using pi. The MISR samples po (combinational from the pre-capture chain) on that same edge.
- scan_so is sampled on the same edge on which test_se=1 shifts the core.
- start in the cycle that DONE is entered has no effect. From DONE, start restarts with zero idle cycles.

## Test plan
- Reset and idle: hold RN=0 then release, no start for 20 cycles -> all outputs 0, signature=16'h0000, test_se never 1.
- Sequence and counting with CHAIN_LEN=4, NUM_PATTERNS=2, core modelled as a 4-bit shift register (scan_so=stage 3, po=0):
  - start -> busy high for exactly 14 cycles, then done=1.
  - test_se pattern 1111 0 1111 0 1111.
  - first test_si bits 1,0,0,0 (SEED LSBs).
- Pattern-0 masking: same setup, but drive scan_so=X during pattern 0 -> signature is never X and is identical to a run with scan_so=0 there.
- Golden compare: run the previous setup, record the signature S, rebuild with GOLDEN=S and rerun -> pass=1. Flip one po bit in one CAPTURE -> pass=0 and signature≠S.
- Restart and abort:
  - start during busy -> ignored, cycle count unchanged.
  - RN pulse low in the 3rd SHIFT cycle -> outputs 0 immediately.
  - A following start -> full 14-cycle run with an identical signature.
- Back-to-back: start held high through DONE -> the second run begins the cycle after DONE and produces a signature identical to the first.

Source files
------------

// File: rtl/scan_bist_ctrl.sv
// ---------------------------------------------------------------------------
// scan_bist_ctrl
// Logic BIST controller for a scan-inserted core. A 16-bit LFSR supplies
// scan-in and primary-input stimulus; a 16-bit MISR compacts scan-out and
// primary outputs. At the end of a run the MISR is compared against GOLDEN.
//
// Ports
//   CK        in   clock, rising edge
//   RN        in   asynchronous active-low reset
//   start     in   run request (honoured only in IDLE/DONE)
//   scan_so   in   core scan-out (last chain cell)
//   po        in   core primary outputs [PO_W]
//   test_se   out  core scan enable
//   test_si   out  core scan-in
//   pi        out  core primary inputs [PI_W]
//   busy      out  run in progress
//   done      out  run complete, held until the next start
//   pass      out  final signature matched GOLDEN (valid with done)
//   signature out  current MISR value
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_SHIFT   | loading LFSR bits into the chain, compacting scan_so
// S_CAPTURE | one cycle with pi applied; core captures, MISR takes po
// S_UNLOAD  | shifting out the last response, compacting scan_so
// S_DONE    | run finished, pass held, start restarts immediately
// ---------------------------------------------------------------------------
module scan_bist_ctrl #(
    parameter int unsigned CHAIN_LEN    = 14,
    parameter int unsigned NUM_PATTERNS = 64,
    parameter int unsigned PI_W         = 3,
    parameter int unsigned PO_W         = 6,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [15:0] GOLDEN       = 16'h0000
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            start,
    input  logic            scan_so,
    input  logic [PO_W-1:0] po,
    output logic            test_se,
    output logic            test_si,
    output logic [PI_W-1:0] pi,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     signature
);

    localparam int unsigned CW = $clog2(CHAIN_LEN);
    localparam int unsigned PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_CAPTURE = 3'd2,
        S_UNLOAD  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [15:0]   misr, misr_nxt;
    logic [CW-1:0] shift_cnt, shift_cnt_nxt;
    logic [PW-1:0] pat_cnt, pat_cnt_nxt;
    logic          pass_nxt;
    logic          shift_last;
    logic          pat_last;

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ d;
    endfunction

    assign shift_last = (shift_cnt == CW'(CHAIN_LEN - 1));
    assign pat_last   = (pat_cnt == PW'(NUM_PATTERNS - 1));
    assign signature  = misr;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            misr      <= '0;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            misr      <= misr_nxt;
            shift_cnt <= shift_cnt_nxt;
            pat_cnt   <= pat_cnt_nxt;
            pass      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr;
        misr_nxt      = misr;
        shift_cnt_nxt = shift_cnt;
        pat_cnt_nxt   = pat_cnt;
        pass_nxt      = pass;
        test_se       = 1'b0;
        test_si       = 1'b0;
        pi            = '0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_nxt     = S_SHIFT;
                    lfsr_nxt      = SEED;
                    misr_nxt      = '0;
                    shift_cnt_nxt = '0;
                    pat_cnt_nxt   = '0;
                    pass_nxt      = 1'b0;
                end
            end

            S_SHIFT: begin
                test_se  = 1'b1;
                test_si  = lfsr[0];
                busy     = 1'b1;
                lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                // The chain holds unreset garbage until the first load completes,
                // so pattern 0 must not reach the signature.
                if (pat_cnt != '0) begin
                    misr_nxt = misr_step(misr, {15'b0, scan_so});
                end
                if (shift_last) begin
                    shift_cnt_nxt = '0;
                    state_nxt     = S_CAPTURE;
                end else begin
                    shift_cnt_nxt = shift_cnt + 1'b1;
                end
            end

            S_CAPTURE: begin
                pi       = lfsr[PI_W:1];
                busy     = 1'b1;
                misr_nxt = misr_step(misr, 16'({po, 1'b0}));
                if (pat_last) begin
                    state_nxt = S_UNLOAD;
                end else begin
                    pat_cnt_nxt = pat_cnt + 1'b1;
                    state_nxt   = S_SHIFT;
                end
            end

            S_UNLOAD: begin
                test_se  = 1'b1;
                busy     = 1'b1;
                misr_nxt = misr_step(misr, {15'b0, scan_so});
                if (shift_last) begin
                    shift_cnt_nxt = '0;
                    state_nxt     = S_DONE;
                    // Compare the value the MISR will hold in DONE.
                    pass_nxt      = (misr_nxt == GOLDEN);
                end else begin
                    shift_cnt_nxt = shift_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_bist_ctrl
// Directed bench for scan_bist_ctrl with CHAIN_LEN=4, NUM_PATTERNS=2. The
// core is a 4-bit scan shift register (scan_so = stage 3, po = 0) that holds
// in capture. Hand-derived expectations for SEED=16'hACE1:
//   test_si pattern 0 = 1,0,0,0 ; pattern 1 = 0,1,1,1
//   pi in capture 0 = 3'b111, capture 1 = 3'b110
//   scan_so pattern 1 = 1,0,0,0 ; unload = 0,1,1,1
//   MISR: 0001,0002,0004,0008 | cap 0010 | 0020,0041,0083,0107 -> S = 16'h0107
//   po[0] flipped in capture 1: 0012 | 0024,0049,0093,0127 -> 16'h0127
// GOLDEN is set to S so a clean run reports pass=1.
// ---------------------------------------------------------------------------
module tb_scan_bist_ctrl;

    localparam logic [15:0] SIG_OK   = 16'h0107;
    localparam logic [15:0] SIG_FLIP = 16'h0127;

    logic       CK = 1'b0;
    logic       RN;
    logic       start;
    logic       scan_so;
    logic [5:0] po;
    logic       test_se;
    logic       test_si;
    logic [2:0] pi;
    logic       busy;
    logic       done;
    logic       pass;
    logic [15:0] signature;

    logic [3:0] ch;
    logic       mask_en;
    logic       mask_val;

    int n_vec = 0;
    int n_err = 0;

    scan_bist_ctrl #(
        .CHAIN_LEN   (4),
        .NUM_PATTERNS(2),
        .PI_W        (3),
        .PO_W        (6),
        .SEED        (16'hACE1),
        .GOLDEN      (SIG_OK)
    ) dut (
        .CK       (CK),
        .RN       (RN),
        .start    (start),
        .scan_so  (scan_so),
        .po       (po),
        .test_se  (test_se),
        .test_si  (test_si),
        .pi       (pi),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .signature(signature)
    );

    always #5 CK = ~CK;

    // Core scan chain: shifts when test_se=1, holds otherwise, never reset.
    always @(posedge CK) begin
        if (test_se) ch <= {ch[2:0], test_si};
    end
    assign scan_so = mask_en ? mask_val : ch[3];

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // One full run launched from IDLE/DONE. Cycle n: 0-3 SHIFT, 4 CAPTURE,
    // 5-8 SHIFT, 9 CAPTURE, 10-13 UNLOAD.
    task automatic run(input bit use_mask, input logic mval, input bit flip, input bit poke,
                       output int ncyc, output logic [13:0] se_bits, output logic [3:0] si_bits,
                       output logic [2:0] pi0, output logic [2:0] pi1);
        int n;
        se_bits  = '0;
        si_bits  = '0;
        pi0      = '0;
        pi1      = '0;
        mask_en  = use_mask;
        mask_val = mval;
        start    = 1'b1;
        step();
        start    = 1'b0;
        n        = 0;
        while (busy === 1'b1 && n < 40) begin
            if (n < 14) se_bits[13-n] = test_se;
            if (n < 4) si_bits[3-n] = test_si;
            if (n == 4) pi0 = pi;
            if (n == 9) begin
                pi1 = pi;
                if (flip) po = 6'b000001;
            end
            if (poke && n == 6) start = 1'b1;
            step();
            po    = '0;
            start = 1'b0;
            n++;
            if (n == 4) mask_en = 1'b0;
        end
        mask_en = 1'b0;
        ncyc    = n;
    endtask

    initial begin
        int          ncyc;
        int          n2;
        logic [13:0] se_bits;
        logic [3:0]  si_bits;
        logic [2:0]  pi0;
        logic [2:0]  pi1;
        logic        se_seen;
        logic        busy_seen;

        RN       = 1'b0;
        start    = 1'b0;
        po       = '0;
        mask_en  = 1'b0;
        mask_val = 1'b0;

        // Reset and idle
        step(); step(); step();
        check("rst_se", 32'(test_se), 0);
        check("rst_busy", 32'(busy), 0);
        RN        = 1'b1;
        se_seen   = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            se_seen   = se_seen | test_se;
            busy_seen = busy_seen | busy;
        end
        check("idle_se_never", 32'(se_seen), 0);
        check("idle_busy_never", 32'(busy_seen), 0);
        check("idle_si", 32'(test_si), 0);
        check("idle_pi", 32'(pi), 0);
        check("idle_done", 32'(done), 0);
        check("idle_pass", 32'(pass), 0);
        check("idle_sig", 32'(signature), 0);

        // Baseline run, pattern-0 scan_so forced to 0
        run(1'b1, 1'b0, 1'b0, 1'b0, ncyc, se_bits, si_bits, pi0, pi1);
        check("run1_cycles", 32'(ncyc), 14);
        check("run1_se_pattern", 32'(se_bits), 32'(14'b11110111101111));
        check("run1_si_first", 32'(si_bits), 32'(4'b1000));
        check("run1_pi_cap0", 32'(pi0), 32'(3'b111));
        check("run1_pi_cap1", 32'(pi1), 32'(3'b110));
        check("run1_done", 32'(done), 1);
        check("run1_sig", 32'(signature), 32'(SIG_OK));
        check("run1_pass", 32'(pass), 1);
        check("run1_se_done", 32'(test_se), 0);
        step(); step(); step();
        check("done_sticky", 32'(done), 1);
        check("sig_hold", 32'(signature), 32'(SIG_OK));
        check("pass_hold", 32'(pass), 1);

        // Pattern-0 masking: X and then 1 on scan_so during pattern 0
        run(1'b1, 1'bx, 1'b0, 1'b0, ncyc, se_bits, si_bits, pi0, pi1);
        check("maskx_sig", 32'(signature), 32'(SIG_OK));
        run(1'b1, 1'b1, 1'b0, 1'b0, ncyc, se_bits, si_bits, pi0, pi1);
        check("mask1_sig", 32'(signature), 32'(SIG_OK));
        check("mask1_pass", 32'(pass), 1);

        // One po bit flipped in the second capture
        run(1'b1, 1'b0, 1'b1, 1'b0, ncyc, se_bits, si_bits, pi0, pi1);
        check("flip_sig", 32'(signature), 32'(SIG_FLIP));
        check("flip_pass", 32'(pass), 0);
        check("flip_done", 32'(done), 1);

        // start while busy is ignored
        run(1'b1, 1'b0, 1'b0, 1'b1, ncyc, se_bits, si_bits, pi0, pi1);
        check("poke_cycles", 32'(ncyc), 14);
        check("poke_sig", 32'(signature), 32'(SIG_OK));
        check("poke_pass", 32'(pass), 1);

        // Abort in the 3rd SHIFT cycle
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("abort_pre_busy", 32'(busy), 1);
        RN = 1'b0;
        #1;
        check("abort_se", 32'(test_se), 0);
        check("abort_si", 32'(test_si), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_sig", 32'(signature), 0);
        step();
        RN = 1'b1;
        step();
        check("abort_idle_busy", 32'(busy), 0);
        // Next run with the stale chain unmasked on the bench side
        run(1'b0, 1'b0, 1'b0, 1'b0, ncyc, se_bits, si_bits, pi0, pi1);
        check("post_abort_cycles", 32'(ncyc), 14);
        check("post_abort_si", 32'(si_bits), 32'(4'b1000));
        check("post_abort_sig", 32'(signature), 32'(SIG_OK));
        check("post_abort_pass", 32'(pass), 1);

        // Back-to-back with start held high
        start = 1'b1;
        step();
        count_busy(ncyc);
        check("b2b_cycles1", 32'(ncyc), 14);
        check("b2b_done1", 32'(done), 1);
        check("b2b_sig1", 32'(signature), 32'(SIG_OK));
        step();
        check("b2b_restart_busy", 32'(busy), 1);
        check("b2b_restart_se", 32'(test_se), 1);
        check("b2b_restart_done", 32'(done), 0);
        start = 1'b0;
        count_busy(n2);
        check("b2b_cycles2", 32'(n2), 14);
        check("b2b_sig2", 32'(signature), 32'(SIG_OK));
        check("b2b_pass2", 32'(pass), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
